// File: rtl/bp_pkg.sv
// -----------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the branch-prediction blocks: opcode constants used
// by the branch decoder and the saturating-counter reset value.
// -----------------------------------------------------------------------------
package bp_pkg;

    // RV32I conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU)
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;

    // RVC quadrant 1; funct3[2:1] = 2'b11 selects c.beqz (110) and c.bnez (111)
    localparam logic [1:0] RVC_OP_C1     = 2'b01;
    localparam logic [1:0] RVC_F3_BRANCH = 2'b11;

    // Weakly not-taken: one below the taken threshold, e.g. 2'b01 or 4'b0111
    function automatic int unsigned cnt_init(input int unsigned cnt_bits);
        return (32'd1 << (cnt_bits - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/branch_imm_dec.sv
// -----------------------------------------------------------------------------
// branch_imm_dec
// Combinational detection of conditional branches and extraction of their
// sign-extended byte offset, for both 32-bit B-type and RVC c.beqz/c.bnez.
//
// Ports:
//   ins        in   32  instruction word (compressed encoding in [15:0])
//   itype      in    1  1 = 32-bit instruction, 0 = compressed
//   is_branch  out   1  instruction is a conditional branch
//   imm        out  32  sign-extended branch offset (bit 0 always 0)
// -----------------------------------------------------------------------------
module branch_imm_dec
    import bp_pkg::*;
(
    input  logic [31:0] ins,
    input  logic        itype,
    output logic        is_branch,
    output logic [31:0] imm
);

    logic [31:0] b_imm;
    logic [31:0] c_imm;
    logic        b_hit;
    logic        c_hit;

    assign b_imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign c_imm = {{23{ins[12]}}, ins[12], ins[6:5], ins[2], ins[11:10], ins[4:3], 1'b0};

    assign b_hit = (ins[6:0] == OPC_BRANCH);
    assign c_hit = (ins[1:0] == RVC_OP_C1) && (ins[15:14] == RVC_F3_BRANCH);

    assign is_branch = itype ? b_hit : c_hit;
    assign imm       = itype ? b_imm : c_imm;

    // Register fields (rs1/rs2/funct3 low bit) play no part in prediction
    logic unused_ins;
    assign unused_ins = ^{ins[24:16], ins[13]};

endmodule

// File: rtl/gshare_predictor.sv
// -----------------------------------------------------------------------------
// gshare_predictor
// Global-history (gshare) conditional-branch predictor. Produces a same-cycle
// next-PC prediction for the fetcher, tagged with the history snapshot it
// used, and trains / repairs itself from branches retired by the ROB.
//
// Ports:
//   clk_in, rst_in        clock, synchronous active-high reset
//   rdy_in                0 = freeze all state (outputs stay combinational)
//   fetch_valid           fetcher consumes pred_pc this cycle
//   fetch_ins/pc/itype    instruction being fetched
//   pred_pc/taken/ghr     prediction and the history it was made with
//   upd_valid             ROB retires a conditional branch
//   upd_pc/taken          retired branch address and real outcome
//   upd_mispredict        the earlier prediction was wrong
//   upd_ghr               history snapshot carried with that branch
//   stat_branches         retired branch count (wraps)
//   stat_mispredicts      retired mispredict count (wraps)
// -----------------------------------------------------------------------------
module gshare_predictor
    import bp_pkg::*;
#(
    parameter int PHT_BITS  = 8,
    parameter int HIST_BITS = 6,
    parameter int CNT_BITS  = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 fetch_valid,
    input  logic [31:0]          fetch_ins,
    input  logic [31:0]          fetch_pc,
    input  logic                 fetch_itype,
    output logic [31:0]          pred_pc,
    output logic                 pred_taken,
    output logic [HIST_BITS-1:0] pred_ghr,
    input  logic                 upd_valid,
    input  logic [31:0]          upd_pc,
    input  logic                 upd_taken,
    input  logic                 upd_mispredict,
    input  logic [HIST_BITS-1:0] upd_ghr,
    output logic [31:0]          stat_branches,
    output logic [31:0]          stat_mispredicts
);

    localparam int                PHT_ENTRIES = 1 << PHT_BITS;
    localparam logic [CNT_BITS-1:0] CNT_INIT  = CNT_BITS'(cnt_init(CNT_BITS));
    localparam logic [CNT_BITS-1:0] CNT_MAX   = '1;

    logic [CNT_BITS-1:0]  pht [PHT_ENTRIES];
    logic [HIST_BITS-1:0] ghr;

    logic                 is_branch;
    logic [31:0]          br_imm;
    logic [PHT_BITS-1:0]  fetch_idx;
    logic [PHT_BITS-1:0]  upd_idx;
    logic [CNT_BITS-1:0]  upd_cnt;
    logic [CNT_BITS-1:0]  trained_cnt;
    logic [HIST_BITS-1:0] spec_ghr;
    logic [HIST_BITS-1:0] repair_ghr;

    branch_imm_dec u_dec (
        .ins       (fetch_ins),
        .itype     (fetch_itype),
        .is_branch (is_branch),
        .imm       (br_imm)
    );

    // ---------------- prediction (combinational) ----------------
    assign fetch_idx  = fetch_pc[PHT_BITS:1] ^ PHT_BITS'(ghr);
    assign upd_idx    = upd_pc[PHT_BITS:1]   ^ PHT_BITS'(upd_ghr);

    // Same-cycle reads see the pre-update counter since pht is only written
    // at the clock edge.
    assign pred_taken = is_branch & pht[fetch_idx][CNT_BITS-1];
    assign pred_pc    = pred_taken ? fetch_pc + br_imm
                                   : fetch_pc + (fetch_itype ? 32'd4 : 32'd2);
    assign pred_ghr   = ghr;

    // ---------------- history shift candidates ----------------
    generate
        if (HIST_BITS == 1) begin : g_hist1
            assign spec_ghr   = pred_taken;
            assign repair_ghr = upd_taken;
        end else begin : g_histn
            assign spec_ghr   = {ghr[HIST_BITS-2:0], pred_taken};
            assign repair_ghr = {upd_ghr[HIST_BITS-2:0], upd_taken};
        end
    endgenerate

    // ---------------- saturating counter update ----------------
    // NOTE: every always_comb output gets a default first so no path can leave
    // it unassigned and infer a latch.
    always_comb begin
        upd_cnt     = pht[upd_idx];
        trained_cnt = upd_cnt;
        if (upd_taken) begin
            if (upd_cnt != CNT_MAX) trained_cnt = upd_cnt + CNT_BITS'(1);
        end else begin
            if (upd_cnt != '0)      trained_cnt = upd_cnt - CNT_BITS'(1);
        end
    end

    // ---------------- state ----------------
    // NOTE: the PHT is plain flops, not a RAM macro, so it can be reset in a
    // loop; a real RAM would need a sweep FSM or a valid-bit scheme instead.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ghr              <= '0;
            stat_branches    <= '0;
            stat_mispredicts <= '0;
            for (int i = 0; i < PHT_ENTRIES; i++) pht[i] <= CNT_INIT;
        end else if (rdy_in) begin
            // A retiring mispredict means the current fetch is wrong-path,
            // so the repair wins over its speculative shift.
            if (upd_valid && upd_mispredict)
                ghr <= repair_ghr;
            else if (fetch_valid && is_branch)
                ghr <= spec_ghr;

            if (upd_valid) begin
                pht[upd_idx]  <= trained_cnt;
                stat_branches <= stat_branches + 32'd1;
                if (upd_mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end

    // Only the index bits of the retired PC matter
    logic unused_upd_pc;
    assign unused_upd_pc = ^{upd_pc[31:PHT_BITS+1], upd_pc[0]};

endmodule

// File: tb/tb_gshare_predictor.sv
// -----------------------------------------------------------------------------
// tb_gshare_predictor
// Directed literal scenarios followed by randomized traffic, with a
// behavioural model (integer table + history word) checked every cycle.
// -----------------------------------------------------------------------------
module tb_gshare_predictor;

    localparam int PHT_BITS  = 8;
    localparam int HIST_BITS = 6;
    localparam int CNT_BITS  = 2;
    localparam int unsigned N_ENT    = 1 << PHT_BITS;
    localparam int unsigned IDX_MASK = N_ENT - 1;
    localparam int unsigned HIST_MASK = (1 << HIST_BITS) - 1;
    localparam int unsigned CNT_TOP  = (1 << CNT_BITS) - 1;
    localparam int unsigned CNT_THR  = 1 << (CNT_BITS - 1);

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_ins = '0;
    logic [31:0] fetch_pc = '0;
    logic        fetch_itype = 1'b1;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic [HIST_BITS-1:0] pred_ghr;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic        upd_mispredict = 1'b0;
    logic [HIST_BITS-1:0] upd_ghr = '0;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    gshare_predictor #(
        .PHT_BITS (PHT_BITS),
        .HIST_BITS(HIST_BITS),
        .CNT_BITS (CNT_BITS)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .fetch_valid     (fetch_valid),
        .fetch_ins       (fetch_ins),
        .fetch_pc        (fetch_pc),
        .fetch_itype     (fetch_itype),
        .pred_pc         (pred_pc),
        .pred_taken      (pred_taken),
        .pred_ghr        (pred_ghr),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_mispredict  (upd_mispredict),
        .upd_ghr         (upd_ghr),
        .stat_branches   (stat_branches),
        .stat_mispredicts(stat_mispredicts)
    );

    always #5 clk_in = ~clk_in;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int unsigned pht_m [N_ENT];
    int unsigned ghr_m;
    int unsigned nbr_m;
    int unsigned nmis_m;
    bit          model_valid = 0;

    function automatic void model_decode(input logic [31:0] ins, input logic it,
                                         output bit br, output int unsigned imm);
        int unsigned w;
        w = ins;
        if (it) begin
            br  = ((w & 32'h7f) == 32'h63);
            imm = (((w >> 31) & 1) << 12) | (((w >> 7) & 1) << 11) |
                  (((w >> 25) & 63) << 5) | (((w >> 8) & 15) << 1);
            if ((imm & 32'h1000) != 0) imm = imm | 32'hFFFFE000;
        end else begin
            br  = ((w & 3) == 1) && (((w >> 14) & 3) == 3);
            imm = (((w >> 12) & 1) << 8) | (((w >> 5) & 3) << 6) |
                  (((w >> 2) & 1) << 5) | (((w >> 10) & 3) << 3) |
                  (((w >> 3) & 3) << 1);
            if ((imm & 32'h100) != 0) imm = imm | 32'hFFFFFE00;
        end
    endfunction

    // Compare on the falling edge (inputs and state settled), then advance
    // the model by what the coming rising edge will do.
    always @(negedge clk_in) begin : cmp
        bit          br;
        int unsigned imm, idx, uidx, exp_taken, exp_pc;
        model_decode(fetch_ins, fetch_itype, br, imm);
        idx       = ((fetch_pc >> 1) & IDX_MASK) ^ ghr_m;
        exp_taken = (br && pht_m[idx] >= CNT_THR) ? 1 : 0;
        exp_pc    = (exp_taken != 0) ? fetch_pc + imm
                                     : fetch_pc + (fetch_itype ? 32'd4 : 32'd2);
        if (model_valid) begin
            check("pred_taken",       {31'd0, pred_taken}, exp_taken);
            check("pred_pc",          pred_pc, exp_pc);
            check("pred_ghr",         {26'd0, pred_ghr}, ghr_m);
            check("stat_branches",    stat_branches, nbr_m);
            check("stat_mispredicts", stat_mispredicts, nmis_m);
        end
        if (rst_in) begin
            for (int i = 0; i < N_ENT; i++) pht_m[i] = CNT_THR - 1;
            ghr_m = 0; nbr_m = 0; nmis_m = 0;
            model_valid = 1;
        end else if (rdy_in) begin
            if (upd_valid && upd_mispredict)
                ghr_m = ((upd_ghr << 1) | upd_taken) & HIST_MASK;
            else if (fetch_valid && br)
                ghr_m = ((ghr_m << 1) | exp_taken) & HIST_MASK;
            if (upd_valid) begin
                uidx = ((upd_pc >> 1) & IDX_MASK) ^ upd_ghr;
                if (upd_taken && pht_m[uidx] < CNT_TOP) pht_m[uidx]++;
                if (!upd_taken && pht_m[uidx] > 0)      pht_m[uidx]--;
                nbr_m++;
                if (upd_mispredict) nmis_m++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(posedge clk_in); #1;
        rst_in = 1'b1; rdy_in = 1'b1; fetch_valid = 1'b0; upd_valid = 1'b0;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
    endtask

    // Inputs set here are sampled by the next rising edge
    task automatic drive(input logic rdy, input logic fv, input logic [31:0] ins,
                         input logic [31:0] pc, input logic it, input logic uv,
                         input logic [31:0] upc, input logic ut, input logic um,
                         input logic [HIST_BITS-1:0] ug);
        @(posedge clk_in); #1;
        rst_in = 1'b0; rdy_in = rdy; fetch_valid = fv; fetch_ins = ins;
        fetch_pc = pc; fetch_itype = it; upd_valid = uv; upd_pc = upc;
        upd_taken = ut; upd_mispredict = um; upd_ghr = ug;
        #1;
    endtask

    localparam logic [31:0] BEQ  = 32'h00208463;  // beq x1,x2,+8
    localparam logic [31:0] CBNZ = 32'h0000E011;  // c.bnez x8,+4
    localparam logic [31:0] CNOP = 32'h00000001;  // c.nop

    initial begin
        do_reset();

        // Cold prediction: weakly not-taken everywhere
        drive(1, 1, BEQ, 32'h100, 1, 0, 0, 0, 0, 0);
        check("lit_reset_taken", {31'd0, pred_taken}, 32'd0);
        check("lit_reset_pc",    pred_pc, 32'h104);
        check("lit_reset_ghr",   {26'd0, pred_ghr}, 32'd0);
        check("lit_reset_stat",  stat_branches, 32'd0);

        // Two taken retirements, then a repair to ghr=0 (trains idx 0x20 only)
        drive(1, 0, 0, 0, 1, 1, 32'h100, 1, 0, 0);
        drive(1, 0, 0, 0, 1, 1, 32'h100, 1, 0, 0);
        drive(1, 0, 0, 0, 1, 1, 32'h040, 0, 1, 0);
        drive(1, 0, BEQ, 32'h100, 1, 0, 0, 0, 0, 0);
        check("lit_trained_taken", {31'd0, pred_taken}, 32'd1);
        check("lit_trained_pc",    pred_pc, 32'h108);

        // Compressed: trained c.bnez, then a non-branch
        drive(1, 0, 0, 0, 1, 1, 32'h200, 1, 0, 0);
        drive(1, 0, 0, 0, 1, 1, 32'h200, 1, 0, 0);
        drive(1, 0, CBNZ, 32'h200, 0, 0, 0, 0, 0, 0);
        check("lit_cbnez_pc", pred_pc, 32'h204);
        drive(1, 0, CNOP, 32'h200, 0, 0, 0, 0, 0, 0);
        check("lit_cnop_pc", pred_pc, 32'h202);

        // Saturation: 5 taken then 1 not-taken leaves the entry taken
        for (int i = 0; i < 5; i++) drive(1, 0, 0, 0, 1, 1, 32'h180, 1, 0, 0);
        drive(1, 0, 0, 0, 1, 1, 32'h180, 0, 0, 0);
        drive(1, 0, BEQ, 32'h180, 1, 0, 0, 0, 0, 0);
        check("lit_sat_taken", {31'd0, pred_taken}, 32'd1);
        check("lit_sat_pc",    pred_pc, 32'h188);

        // Repair beats a same-cycle speculative shift of a taken branch
        drive(1, 1, BEQ, 32'h100, 1, 1, 32'h040, 1, 1, 6'b000101);
        check("lit_spec_taken", {31'd0, pred_taken}, 32'd1);
        drive(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        check("lit_repair_ghr", {26'd0, pred_ghr}, 32'b001011);

        // rdy_in low freezes everything
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, BEQ, 32'h100, 1, 1, 32'h100, 1, 1, 0);
            check("lit_hold_stat", stat_branches, 32'd0);
            check("lit_hold_taken", {31'd0, pred_taken}, 32'd0);
            check("lit_hold_ghr", {26'd0, pred_ghr}, 32'd0);
        end
        drive(1, 0, BEQ, 32'h100, 1, 1, 32'h100, 1, 0, 0);
        check("lit_hold_stat_final", stat_branches, 32'd0);
        drive(1, 0, BEQ, 32'h100, 1, 0, 0, 0, 0, 0);
        check("lit_release_stat",  stat_branches, 32'd1);
        check("lit_release_mis",   stat_mispredicts, 32'd0);
        check("lit_release_taken", {31'd0, pred_taken}, 32'd1);

        // Randomized traffic on a small PC window so entries get trained
        for (int n = 0; n < 4000; n++) begin
            logic [31:0] ins, pc, upc;
            logic        it;
            int          sel;
            if ($urandom_range(0, 999) == 0) do_reset();
            sel = $urandom_range(0, 2);
            ins = $urandom;
            it  = 1'b1;
            if (sel == 0) begin
                ins[6:0] = 7'b1100011;
            end else if (sel == 1) begin
                ins[15:14] = 2'b11; ins[1:0] = 2'b01; it = 1'b0;
            end else begin
                it = 1'($urandom_range(0, 1));
            end
            pc  = ($urandom_range(0, 7) == 0) ? ($urandom & ~32'd1)
                                              : 32'h1000 + ($urandom_range(0, 31) << 1);
            upc = 32'h1000 + ($urandom_range(0, 31) << 1);
            drive(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), ins, pc, it,
                  1'($urandom_range(0, 1)), upc, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) == 0), HIST_BITS'($urandom));
        end

        drive(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        @(posedge clk_in); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gshare_predictor.md
# gshare_predictor

Parametrised gshare conditional-branch predictor for the Issue stage, the successor to the per-PC 2-bit table. The instruction fetcher gets a same-cycle combinational next-PC prediction for RV32I B-type and RVC c.beqz/c.bnez branches. Each prediction comes with the global-history snapshot it used. The ROB retires branch outcomes back into the block to train saturating counters, repair the speculative global history on a mispredict, and maintain retirement statistics.

## Interface
Parameters:
- PHT_BITS, 8, log2 of pattern-history-table entries; index taken from pc[PHT_BITS:1]
- HIST_BITS, 6, global history length; legal range 1..PHT_BITS
- CNT_BITS, 2, saturating counter width; legal range 2..4

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset; synchronous, active-high
- rdy_in  input  1  when low, all state holds; combinational outputs stay live
- fetch_valid  input  1  fetcher consumes pred_pc this cycle
- fetch_ins  input  32  instruction word (RVC in [15:0])
- fetch_pc  input  32  instruction address
- fetch_itype  input  1  1 = 32-bit, 0 = compressed
- pred_pc  output  32  predicted next PC
- pred_taken  output  1  branch predicted taken
- pred_ghr  output  HIST_BITS  GHR value used for this prediction, carried to the ROB
- upd_valid  input  1  ROB retires a conditional branch
- upd_pc  input  32  PC of the retired branch
- upd_taken  input  1  actual outcome
- upd_mispredict  input  1  pred_taken differed from the outcome
- upd_ghr  input  HIST_BITS  pred_ghr captured when the branch was fetched
- stat_branches  output  32  count of retired branches
- stat_mispredicts  output  32  count of retired mispredicts

## Operation
- Branch detect: Itype with ins[6:0]=1100011, or compressed with ins[1:0]=01 and ins[15:14]=11.
- B immediate: sign-extend {ins[31],ins[7],ins[30:25],ins[11:8],0}.
- RVC immediate: sign-extend {ins[12],ins[6:5],ins[2],ins[11:10],ins[4:3],0}. Bit 0 is always 0.
- Fetch index: fetch_pc[PHT_BITS:1] XOR zero-extended ghr.
- Update index: upd_pc[PHT_BITS:1] XOR zero-extended upd_ghr.
- pred_taken = is_branch & MSB of the indexed counter.
- pred_pc = pred_taken ? fetch_pc+imm : fetch_pc + (fetch_itype ? 4 : 2). Arithmetic is 32-bit modulo.
- pred_ghr = current speculative ghr.
- Speculative history: on fetch_valid & is_branch, ghr <= {ghr[HIST_BITS-2:0], pred_taken}.
- Repair: on upd_valid & upd_mispredict, ghr <= {upd_ghr[HIST_BITS-2:0], upd_taken}. Repair overrides a same-cycle speculative shift, because that fetch is wrong-path.
- Training: on upd_valid, the counter at the update index increments if taken (saturating at 2^CNT_BITS-1), otherwise decrements (saturating at 0).
- Statistics: stat_branches +1 on every upd_valid. stat_mispredicts +1 when upd_mispredict is also set. Both wrap at 2^32.

## Timing
- Reset: all counters = 2^(CNT_BITS-1)-1 (weakly not-taken), ghr = 0, both stats = 0.
- After reset, pred_taken = 0 and pred_pc = fetch_pc+4/+2.
- Prediction latency is 0 cycles (combinational from fetch_* and registered state).
- Every update is visible to predictions from the next cycle onward.
- Same-cycle update and fetch to the same PHT entry: the read returns the pre-update value.
- rdy_in low: no counter, ghr or stat change, even if fetch_valid or upd_valid is high.
- rst_in takes priority over rdy_in and all inputs.
- Reset asserted mid-stream discards pending history; later upd_ghr values are used as given.
- fetch_valid on a non-branch leaves ghr unchanged.
- upd_valid with upd_mispredict=0 trains the PHT only.

## Structure
- Shared package bp_pkg holds:
  - OPC_BRANCH = 7'b1100011
  - RVC branch opcode/funct3 constants
  - function cnt_init(CNT_BITS)
- Sub-module branch_imm_dec: combinational decode of {is_branch, imm[31:0]} from ins and itype.
- The PHT is a flat register array with reset loop, no RAM macro.

## Test plan
- Reset, then fetch BEQ 0x00208463 at pc 0x100, itype=1 -> pred_taken=0, pred_pc=0x104, pred_ghr=0.
- Two retired taken updates (upd_pc 0x100, upd_ghr=0), then the same fetch with ghr forced back to 0 through a mispredict repair -> pred_taken=1, pred_pc=0x108.
- c.bnez 0xE011 at pc 0x200 with its counter trained taken -> pred_pc=0x204. A compressed non-branch -> pred_pc=0x202.
- Saturation: 5 taken updates then 1 not-taken on one entry -> prediction is still taken.
- Simultaneous fetch_valid branch and upd_valid mispredict with upd_ghr=6'b000101, taken=1 -> next ghr=6'b001011, with no speculative shift applied.
- rdy_in=0 for 3 cycles with upd_valid=1 -> stats and counters unchanged. rdy_in=1 -> stat_branches increments by exactly 1.
